// File: rtl/fp_sched_pkg.sv
// Shared types, widths and sizing helpers for the fp_convert_scheduler slice.
package fp_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_SHOW    = 2'd2
  } sched_state_t;

  localparam int FP_WIDTH = 32;

  // clog2 that never returns 0, so single-value ranges still get a 1-bit vector
  function automatic int safe_clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return safe_clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at/after ptr wins, wrapping N-1 -> 0.
// Define FP_SCHED_FIXED_PRI_EN to force the search start to 0 (lowest index wins).
module rr_arbiter
  import fp_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = safe_clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] start_s;
  logic          found_s;
  int            cand_s;

  // Rotating priority search starting at start_s
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    cand_s  = 0;
`ifdef FP_SCHED_FIXED_PRI_EN
    start_s = '0;
`else
    start_s = ptr;
`endif
    for (int i = 0; i < N; i++) begin
      cand_s = (int'(start_s) + i) % N;
      if (!found_s && req[cand_s]) begin
        found_s      = 1'b1;
        gnt[cand_s]  = 1'b1;
        gnt_idx      = IW'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fp_convert_scheduler.sv
// Time-shares one fp_convertor/7-seg path among NUM_REQ float requesters.
// Define FP_SCHED_FIXED_PRI_EN for fixed (lowest index) priority instead of round-robin.
module fp_convert_scheduler
  import fp_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CONV_LATENCY = 40,
  parameter int HOLD_CYCLES  = 50_000_000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [FP_WIDTH-1:0]               floating_point,
  output logic                              fp_load,
  output logic [safe_clog2(NUM_REQ)-1:0]    grant_id,
  output logic                              display_valid,
  output logic                              busy
);

  localparam int IW = safe_clog2(NUM_REQ);
  localparam int CW = cnt_width(CONV_LATENCY, HOLD_CYCLES);

  sched_state_t         state_r, state_nx_s;
  logic [FP_WIDTH-1:0]  fp_r, fp_nx_s;
  logic                 fp_load_r, fp_load_nx_s;
  logic [IW-1:0]        grant_r, grant_nx_s;
  logic                 dv_r, dv_nx_s;
  logic                 busy_r, busy_nx_s;
  logic [CW-1:0]        cnt_r, cnt_nx_s;
  logic [IW-1:0]        ptr_r, ptr_nx_s;
  logic [NUM_REQ-1:0]   gnt_s;
  logic [IW-1:0]        gnt_idx_s;
  logic [NUM_REQ-1:0]   ready_s;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Next-state and next-register values for the scheduler FSM
  always_comb begin
    state_nx_s   = state_r;
    fp_nx_s      = fp_r;
    fp_load_nx_s = 1'b0;
    grant_nx_s   = grant_r;
    dv_nx_s      = dv_r;
    cnt_nx_s     = cnt_r;
    ptr_nx_s     = ptr_r;
    case (state_r)
      S_IDLE: begin
        if (|req_valid) begin
          state_nx_s   = S_CONVERT;
          fp_nx_s      = req_data[gnt_idx_s];
          fp_load_nx_s = 1'b1;
          grant_nx_s   = gnt_idx_s;
          dv_nx_s      = 1'b0;
          cnt_nx_s     = '0;
`ifdef FP_SCHED_FIXED_PRI_EN
          ptr_nx_s     = '0;
`else
          ptr_nx_s     = (gnt_idx_s == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_s + IW'(1);
`endif
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_CONVERT: begin
        if (cnt_r == CW'(CONV_LATENCY - 1)) begin
          state_nx_s = S_SHOW;
          dv_nx_s    = 1'b1;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      S_SHOW: begin
        if (cnt_r == CW'(HOLD_CYCLES - 1)) begin
          state_nx_s = S_IDLE;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        cnt_nx_s   = '0;
      end
    endcase
    busy_nx_s = (state_nx_s != S_IDLE);
  end

  // Accept strobe: only in IDLE, and suppressed while reset is asserted
  always_comb begin
    ready_s = '0;
    if ((state_r == S_IDLE) && reset) begin
      ready_s = gnt_s;
    end else begin
      ready_s = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      fp_r      <= '0;
      fp_load_r <= 1'b0;
      grant_r   <= '0;
      dv_r      <= 1'b0;
      busy_r    <= 1'b0;
      cnt_r     <= '0;
      ptr_r     <= '0;
    end else begin
      state_r   <= state_nx_s;
      fp_r      <= fp_nx_s;
      fp_load_r <= fp_load_nx_s;
      grant_r   <= grant_nx_s;
      dv_r      <= dv_nx_s;
      busy_r    <= busy_nx_s;
      cnt_r     <= cnt_nx_s;
      ptr_r     <= ptr_nx_s;
    end
  end

  assign req_ready      = ready_s;
  assign floating_point = fp_r;
  assign fp_load        = fp_load_r;
  assign grant_id       = grant_r;
  assign display_valid  = dv_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_fp_convert_scheduler.sv
// Directed self-checking bench for fp_convert_scheduler (NUM_REQ=4, CONV_LATENCY=3, HOLD_CYCLES=5).
module tb_fp_convert_scheduler;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic [31:0]      floating_point;
  logic             fp_load;
  logic [1:0]       grant_id;
  logic             display_valid;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  fp_convert_scheduler #(.NUM_REQ(4), .CONV_LATENCY(3), .HOLD_CYCLES(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .floating_point (floating_point),
    .fp_load        (fp_load),
    .grant_id       (grant_id),
    .display_valid  (display_valid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_fp"},    floating_point, 32'h0);
    check({tag, "_load"},  {31'b0, fp_load}, 32'h0);
    check({tag, "_grant"}, {30'b0, grant_id}, 32'h0);
    check({tag, "_dv"},    {31'b0, display_valid}, 32'h0);
    check({tag, "_busy"},  {31'b0, busy}, 32'h0);
    check({tag, "_ready"}, {28'b0, req_ready}, 32'h0);
  endtask

  int          exp_g[4];
  int          num_g;
  int          n;
  int          last_acc;
  logic [3:0]  oh;
  logic [31:0] vals[4];

  initial begin
    vals[0] = 32'h3F800000;
    vals[1] = 32'h40000000;
    vals[2] = 32'h40400000;
    vals[3] = 32'h40800000;
    reset     = 1'b0;
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) req_data[i] = vals[i];
    #12;
    check_zero_outputs("por");
    reset = 1'b1;
    tick();
    check("idle_ready", {28'b0, req_ready}, 32'h0);
    check("idle_busy",  {31'b0, busy}, 32'h0);

    // Single request on requester 2
    req_data[2] = 32'h3FC00000;
    req_valid   = 4'b0100;
    #1;
    check("single_ready_T", {28'b0, req_ready}, 32'h4);
    tick();
    check("single_fp",    floating_point, 32'h3FC00000);
    check("single_load",  {31'b0, fp_load}, 32'h1);
    check("single_grant", {30'b0, grant_id}, 32'h2);
    check("single_busy",  {31'b0, busy}, 32'h1);
    check("single_dv_T1", {31'b0, display_valid}, 32'h0);
    check("conv_ready",   {28'b0, req_ready}, 32'h0);
    req_valid = 4'b0000;
    tick();
    check("load_pulse_end", {31'b0, fp_load}, 32'h0);
    tick();
    check("dv_T3", {31'b0, display_valid}, 32'h0);
    tick();
    check("dv_T4", {31'b0, display_valid}, 32'h1);
    req_data[0] = 32'h40490FDB;
    req_valid   = 4'b0001;
    #1;
    check("show_ready_T4", {28'b0, req_ready}, 32'h0);
    for (int i = 5; i <= 8; i++) begin
      tick();
      check($sformatf("no_accept_T%0d", i), {28'b0, req_ready}, 32'h0);
    end
    tick();
    check("accept_T9", {28'b0, req_ready}, 32'h1);
    tick();
    check("second_fp",    floating_point, 32'h40490FDB);
    check("second_grant", {30'b0, grant_id}, 32'h0);
    req_valid = 4'b0000;

    // Withdrawn request during CONVERT
    req_valid = 4'b0010;
    #1;
    check("wd_ready0", {28'b0, req_ready}, 32'h0);
    tick();
    check("wd_ready1", {28'b0, req_ready}, 32'h0);
    req_valid = 4'b0000;
    for (int i = 0; i < 7; i++) tick();
    check("wd_busy", {31'b0, busy}, 32'h0);
    check("wd_fp",   floating_point, 32'h40490FDB);
    // Idle hold with no requests
    for (int i = 0; i < 3; i++) tick();
    check("hold_fp",    floating_point, 32'h40490FDB);
    check("hold_grant", {30'b0, grant_id}, 32'h0);
    check("hold_dv",    {31'b0, display_valid}, 32'h1);
    check("hold_ready", {28'b0, req_ready}, 32'h0);

    // Accept on requester 3, then reset in SHOW
    req_valid = 4'b1000;
    #1;
`ifdef FP_SCHED_FIXED_PRI_EN
    check("r3_ready", {28'b0, req_ready}, 32'h8);
`else
    check("r3_ready", {28'b0, req_ready}, 32'h8);
`endif
    tick();
    check("r3_grant", {30'b0, grant_id}, 32'h3);
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    check("r3_show_dv", {31'b0, display_valid}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("mid_show_rst");
    #3;
    reset = 1'b1;
    tick();
    check("post_rst_busy",  {31'b0, busy}, 32'h0);
    check("post_rst_ready", {28'b0, req_ready}, 32'h0);

    // Arbitration sequence with held requests
    for (int i = 0; i < 4; i++) req_data[i] = vals[i];
`ifdef FP_SCHED_FIXED_PRI_EN
    req_valid = 4'b1001;
    exp_g = '{0, 0, 0, 0};
    num_g = 3;
`else
    req_valid = 4'b1011;
    exp_g = '{0, 1, 3, 0};
    num_g = 4;
`endif
    #1;
    last_acc = 0;
    for (int k = 0; k < num_g; k++) begin
      n = 0;
      while (req_ready == 4'b0000 && n < 20) begin
        tick();
        n++;
      end
      oh = 4'b0001 << exp_g[k];
      check($sformatf("arb_ready_%0d", k), {28'b0, req_ready}, {28'b0, oh});
      if (k > 0) check($sformatf("arb_gap_%0d", k), cyc - last_acc, 32'd9);
      last_acc = cyc;
      tick();
      check($sformatf("arb_grant_%0d", k), {30'b0, grant_id}, exp_g[k]);
      check($sformatf("arb_fp_%0d", k), floating_point, vals[exp_g[k]]);
    end
    req_valid = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
